// File: rtl/mc_controller_if.sv
// mc_controller_if -- control bundle between the multicycle controller and
// its datapath.
//
// Signals:
//   op        [6:0] instruction opcode field (instr[6:0])
//   zero            ALU zero flag
//   mem_ready       memory handshake (only when MC_CTRL_WAIT_EN is defined)
//   immsrc    [1:0] extender select: 00 I, 01 S, 10 B, 11 J
//   alusrca   [1:0] ALU operand A select
//   alusrcb   [1:0] ALU operand B select
//   resultsrc [1:0] result mux select
//   aluop     [1:0] ALU operation class
//   adrsrc          memory address select
//   irwrite         instruction register write enable
//   pcwrite         program counter write enable
//   regwrite        register file write enable
//   memwrite        data memory write enable
//   illegal         one-cycle pulse on an unsupported opcode
//   state     [3:0] current controller state (debug)
//
// Modports: master = controller side, slave = datapath side.
// Configuration macro: MC_CTRL_WAIT_EN adds the mem_ready handshake.

interface mc_controller_if;
  logic [6:0] op;
  logic       zero;
`ifdef MC_CTRL_WAIT_EN
  logic       mem_ready;
`endif
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic [1:0] aluop;
  logic       adrsrc;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegal;
  logic [3:0] state;

`ifdef MC_CTRL_WAIT_EN
  modport master (
    input  op, zero, mem_ready,
    output immsrc, alusrca, alusrcb, resultsrc, aluop,
           adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal, state
  );
  modport slave (
    output op, zero, mem_ready,
    input  immsrc, alusrca, alusrcb, resultsrc, aluop,
           adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal, state
  );
`else
  modport master (
    input  op, zero,
    output immsrc, alusrca, alusrcb, resultsrc, aluop,
           adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal, state
  );
  modport slave (
    output op, zero,
    input  immsrc, alusrca, alusrcb, resultsrc, aluop,
           adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal, state
  );
`endif
endinterface

// File: rtl/mc_controller.sv
// mc_controller -- Moore control FSM for a multicycle RV32 subset core
// (lw, sw, R-type, I-type ALU, beq, jal).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, synchronous release
//   bus    mc_controller_if.master: opcode/zero in, datapath controls out
//
// Configuration macro: MC_CTRL_WAIT_EN -- when defined, FETCH, MEMREAD and
// MEMWRITE stall while bus.mem_ready is low. When undefined the handshake
// does not exist and memory is treated as always ready.

module mc_controller (
  input  logic              clk,
  input  logic              reset,
  mc_controller_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_reg;
  state_t state_next;
  logic   mem_ready;
  logic   pcupdate;
  logic   branch;

`ifdef MC_CTRL_WAIT_EN
  assign mem_ready = bus.mem_ready;
`else
  assign mem_ready = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYP:      state_next = S_EXECUTER;
          OP_ITYP:      state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but lw is a store.
      S_MEMADR:   state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      default:    state_next = S_FETCH;  // unused codes 11-15 recover
    endcase
  end

  // Output logic (Moore on state; pcwrite also folds in the live zero flag)
  always_comb begin
    bus.adrsrc    = 1'b0;
    bus.irwrite   = 1'b0;
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    bus.resultsrc = 2'b00;
    bus.aluop     = 2'b00;
    bus.regwrite  = 1'b0;
    bus.memwrite  = 1'b0;
    bus.illegal   = 1'b0;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // The IR and PC may only load once the fetched word is valid, so a
        // stalled fetch keeps both enables low.
        bus.irwrite   = mem_ready;
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        pcupdate      = mem_ready;
      end
      S_DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW, OP_RTYP, OP_ITYP, OP_BEQ, OP_JAL: bus.illegal = 1'b0;
          default:                                        bus.illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        bus.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        bus.resultsrc = 2'b01;
        bus.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adrsrc   = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        bus.alusrca = 2'b10;
        bus.aluop   = 2'b10;
      end
      S_EXECUTEI: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        bus.aluop   = 2'b10;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
      end
      S_BEQ: begin
        bus.alusrca = 2'b10;
        bus.aluop   = 2'b01;
        branch      = 1'b1;
      end
      S_JAL: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        pcupdate    = 1'b1;
      end
      default: begin
      end
    endcase
    bus.pcwrite = pcupdate | (branch & bus.zero);
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (bus.op)
      OP_SW:   bus.immsrc = 2'b01;
      OP_BEQ:  bus.immsrc = 2'b10;
      OP_JAL:  bus.immsrc = 2'b11;
      default: bus.immsrc = 2'b00;
    endcase
  end

  assign bus.state = state_reg;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller -- self-checking bench for mc_controller.
// Each instruction's expected trace comes from its class (state list,
// write counts) and the per-state control table.

module tb_mc_controller;

  logic clk;
  logic reset;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_seq[$];

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BEQ) || (o == JAL);
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  // {adrsrc, irwrite, alusrca, alusrcb, resultsrc, aluop, regwrite, memwrite}
  function automatic logic [11:0] exp_ctrl(input int st);
    case (st)
      0:  return {1'b0, 1'b1, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
      1:  return {1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
      2:  return {1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
      3:  return {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0};
      5:  return {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
      6:  return {1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
      7:  return {1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0};
      8:  return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
      9:  return {1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0};
      10: return {1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] obs_ctrl();
    return {bus.adrsrc, bus.irwrite, bus.alusrca, bus.alusrcb, bus.resultsrc,
            bus.aluop, bus.regwrite, bus.memwrite};
  endfunction

  // Visited states for one instruction, by instruction class.
  task automatic build_seq(input logic [6:0] o);
    exp_seq = '{0, 1};
    if (o == LW)       exp_seq = '{0, 1, 2, 3, 4};
    else if (o == SW)  exp_seq = '{0, 1, 2, 5};
    else if (o == RT)  exp_seq = '{0, 1, 6, 8};
    else if (o == IT)  exp_seq = '{0, 1, 7, 8};
    else if (o == BEQ) exp_seq = '{0, 1, 9};
    else if (o == JAL) exp_seq = '{0, 1, 10, 8};
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge after
  // the instruction's last cycle. zmode: 0/1 fixed zero, 2 random.
  task automatic run_instr(input int txn, input logic [6:0] o, input int zmode);
    int rw = 0;
    int mw = 0;
    int iw = 0;
    int pw = 0;
    int il = 0;
    int exp_pw = 0;
    int st;
    build_seq(o);
    for (int k = 0; k < exp_seq.size(); k++) begin
      st = exp_seq[k];
      bus.op = o;
      bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      #1;
      check("state", 32'(bus.state), 32'(st));
      check("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(st)));
      check("immsrc", 32'(bus.immsrc), 32'(exp_imm(o)));
      check("pcwrite", 32'(bus.pcwrite),
            32'((st == 0) || (st == 10) || (st == 9 && bus.zero)));
      check("illegal", 32'(bus.illegal), 32'(st == 1 && !is_legal(o)));
      if ((st == 0) || (st == 10) || (st == 9 && bus.zero)) exp_pw++;
      rw += int'(bus.regwrite);
      mw += int'(bus.memwrite);
      iw += int'(bus.irwrite);
      pw += int'(bus.pcwrite);
      il += int'(bus.illegal);
      @(negedge clk);
    end
    #1;
    check("end_state", 32'(bus.state), 32'd0);
    check("irwrite_cnt", 32'(iw), 32'd1);
    check("regwrite_cnt", 32'(rw), 32'((o == LW) || (o == RT) || (o == IT) || (o == JAL)));
    check("memwrite_cnt", 32'(mw), 32'(o == SW));
    check("pcwrite_cnt", 32'(pw), 32'(exp_pw));
    check("illegal_cnt", 32'(il), 32'(!is_legal(o)));
    $display("txn %0d op=%b cycles=%0d regwrite=%0d memwrite=%0d pcwrite=%0d illegal=%0d",
             txn, o, exp_seq.size(), rw, mw, pw, il);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal_ops [6];
    logic [6:0] o;
    int txn = 0;
    legal_ops = '{LW, SW, RT, IT, BEQ, JAL};

    bus.op = 7'd0;
    bus.zero = 1'b0;
`ifdef MC_CTRL_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0)));
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_pcwrite", 32'(bus.pcwrite), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Directed: one of each class, both beq outcomes, an illegal opcode.
    run_instr(txn++, LW, 2);
    run_instr(txn++, SW, 2);
    run_instr(txn++, BEQ, 1);
    run_instr(txn++, BEQ, 0);
    run_instr(txn++, JAL, 2);
    run_instr(txn++, 7'b1111111, 2);
    run_instr(txn++, RT, 2);
    run_instr(txn++, IT, 2);

    // Reset during MEMREAD abandons the load with no write-back.
    bus.op = LW;
    for (int k = 0; k < 3; k++) @(negedge clk);
    #1;
    check("pre_rst_state", 32'(bus.state), 32'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_regwrite", 32'(bus.regwrite), 32'd0);
    check("mid_rst_memwrite", 32'(bus.memwrite), 32'd0);
    @(negedge clk);
    check("held_rst_state", 32'(bus.state), 32'd0);
    check("held_rst_regwrite", 32'(bus.regwrite), 32'd0);
    reset = 1'b1;
    run_instr(txn++, LW, 2);

`ifdef MC_CTRL_WAIT_EN
    // Fetch stall: three not-ready cycles, then the enabling cycle.
    bus.op = RT;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_state", 32'(bus.state), 32'd0);
      check("stall_irwrite", 32'(bus.irwrite), 32'd0);
      check("stall_pcwrite", 32'(bus.pcwrite), 32'd0);
      @(negedge clk);
    end
    bus.mem_ready = 1'b1;
    run_instr(txn++, RT, 2);
`endif

    // Random instruction stream; roughly one in seven is unsupported.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        o = 7'($urandom_range(0, 127));
        for (int t = 0; t < 64 && is_legal(o); t++) o = 7'($urandom_range(0, 127));
        if (is_legal(o)) o = 7'b1111111;
      end else begin
        o = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(txn++, o, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
